eth_tx_frame_arbiter: RTL

- Frame-granular arbiter sharing the single 8-bit MAC TX AXI-stream input among S_COUNT requesters in the tx_clk domain. It sits between per-source TX paths (host, PAUSE/control generator) and the MAC TX FIFO or MAC input.
- Grants a whole frame at a time: round-robin, with optional strict priority for source 0.
- Truncates frames longer than MAX_FRAME_LEN, marks them bad (tuser=1) and discards the remainder.

---
 rtl/eth_pkg.sv | 12 +
 rtl/eth_tx_frame_arbiter_rr_pick.sv | 34 +++
 rtl/eth_tx_frame_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet TX frame arbiter: FSM encoding and default frame limit.
package eth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_t;

  localparam int DEFAULT_MAX_FRAME_LEN = 1518;

endpackage

// File: rtl/eth_tx_frame_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after last_idx (wrapping),
// with optional strict priority for requester 0.
module eth_rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_idx,
  input  logic          prio_en,
  output logic [IW-1:0] pick_idx,
  output logic          pick_valid
);

  logic [IW-1:0] cand;

  always_comb begin
    pick_idx   = '0;
    pick_valid = 1'b0;
    cand       = '0;
    if (prio_en && req[0]) begin
      pick_valid = 1'b1;
    end else begin
      // Walk from farthest to nearest so the nearest match is the final write.
      for (int i = N; i >= 1; i--) begin
        cand = IW'((int'(last_idx) + i) % N);
        if (req[cand]) begin
          pick_valid = 1'b1;
          pick_idx   = cand;
        end
      end
    end
  end

endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-granular arbiter sharing one 8-bit MAC TX AXI-stream among S_COUNT sources.
// Oversize frames are cut at MAX_FRAME_LEN, marked bad, and their tail drained.
module eth_tx_frame_arbiter
  import eth_pkg::*;
#(
  parameter int S_COUNT       = 4,
  parameter int PRIO_SRC0     = 1,
  parameter int MAX_FRAME_LEN = DEFAULT_MAX_FRAME_LEN,
  parameter int LEN_WIDTH     = $clog2(MAX_FRAME_LEN + 1),
  parameter int IW            = $clog2(S_COUNT)
) (
  input  logic                 tx_clk,
  input  logic                 tx_rst,
  input  logic [S_COUNT*8-1:0] s_axis_tdata,
  input  logic [S_COUNT-1:0]   s_axis_tvalid,
  output logic [S_COUNT-1:0]   s_axis_tready,
  input  logic [S_COUNT-1:0]   s_axis_tlast,
  input  logic [S_COUNT-1:0]   s_axis_tuser,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  input  logic                 enable,
  output logic                 grant_valid,
  output logic [IW-1:0]        grant_index,
  output logic                 stat_oversize,
  output arb_state_t           dbg_state
);

  // Handshake: a beat moves on an interface at a rising tx_clk edge exactly when
  // tvalid and tready are both high; tvalid never waits on tready, and data/last/user
  // are held stable while tvalid=1 and tready=0.

  arb_state_t           state, state_nxt;
  logic [IW-1:0]        last_grant;
  logic [LEN_WIDTH-1:0] len_cnt;
  logic                 idle_wait;

  logic [IW-1:0] pick_idx;
  logic          pick_valid;

  logic [7:0] sel_data;
  logic       sel_valid, sel_last, sel_user;

  logic       grant_load, push, trunc, frame_end;
  logic [9:0] push_beat;

  logic [9:0] skid_b0, skid_b1;
  logic [1:0] skid_cnt;
  logic       out_ready, pop;

  eth_rr_pick #(
    .N  (S_COUNT),
    .IW (IW)
  ) u_pick (
    .req        (s_axis_tvalid),
    .last_idx   (last_grant),
    .prio_en    (PRIO_SRC0 != 0),
    .pick_idx   (pick_idx),
    .pick_valid (pick_valid)
  );

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_user  = 1'b0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (grant_index == IW'(i)) begin
        sel_data  = s_axis_tdata[i*8 +: 8];
        sel_valid = s_axis_tvalid[i];
        sel_last  = s_axis_tlast[i];
        sel_user  = s_axis_tuser[i];
      end
    end
  end

  // Output skid stage: free-entry flag comes from the occupancy register only.
  assign out_ready     = (skid_cnt != 2'd2);
  assign m_axis_tvalid = (skid_cnt != 2'd0);
  assign m_axis_tdata  = skid_b0[7:0];
  assign m_axis_tlast  = skid_b0[8];
  assign m_axis_tuser  = skid_b0[9];
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign dbg_state     = state;

  always_comb begin
    state_nxt     = state;
    s_axis_tready = '0;
    grant_load    = 1'b0;
    push          = 1'b0;
    trunc         = 1'b0;
    frame_end     = 1'b0;
    push_beat     = {sel_user, sel_last, sel_data};
    case (state)
      ST_IDLE: begin
        // idle_wait gives the source that just finished one cycle to update tvalid.
        if (!idle_wait && enable && pick_valid) begin
          grant_load = 1'b1;
          state_nxt  = ST_XFER;
        end
      end
      ST_XFER: begin
        s_axis_tready[grant_index] = out_ready;
        if (out_ready && sel_valid) begin
          push = 1'b1;
          if (sel_last) begin
            frame_end = 1'b1;
            state_nxt = ST_IDLE;
          end else if (len_cnt == LEN_WIDTH'(MAX_FRAME_LEN - 1)) begin
            trunc     = 1'b1;
            push_beat = {1'b1, 1'b1, sel_data};
            state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        s_axis_tready[grant_index] = 1'b1;
        if (sel_valid && sel_last) begin
          frame_end = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      state         <= ST_IDLE;
      grant_index   <= '0;
      grant_valid   <= 1'b0;
      last_grant    <= IW'(S_COUNT - 1);
      len_cnt       <= '0;
      stat_oversize <= 1'b0;
      idle_wait     <= 1'b0;
    end else begin
      state         <= state_nxt;
      stat_oversize <= trunc;
      if (grant_load) begin
        grant_index <= pick_idx;
        grant_valid <= 1'b1;
        len_cnt     <= '0;
      end else if (push) begin
        len_cnt <= len_cnt + 1'b1;
      end
      if (frame_end) begin
        last_grant  <= grant_index;
        grant_valid <= 1'b0;
        idle_wait   <= 1'b1;
      end else if (state == ST_IDLE) begin
        idle_wait <= 1'b0;
      end
    end
  end

  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      skid_cnt <= 2'd0;
      skid_b0  <= '0;
      skid_b1  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (skid_cnt == 2'd0) skid_b0 <= push_beat;
          else                  skid_b1 <= push_beat;
          skid_cnt <= skid_cnt + 2'd1;
        end
        2'b01: begin
          skid_b0  <= skid_b1;
          skid_cnt <= skid_cnt - 2'd1;
        end
        2'b11: begin
          if (skid_cnt == 2'd1) begin
            skid_b0 <= push_beat;
          end else begin
            skid_b0 <= skid_b1;
            skid_b1 <= push_beat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
